// File: rtl/rand_pkg.sv
// rtl/rand_pkg.sv - shared types and LFSR constants for the random arbiter
package rand_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STEP  = 2'd1,
        GRANT = 2'd2
    } state_t;

    localparam int LFSR_W = 8;

    // Feedback taps at bits 4, 3, 2 and 0
    localparam logic [LFSR_W-1:0] TAP_MASK = 8'b0001_1101;

    // The all-zero state is a lock-up point; it is replaced by this value on a step
    localparam logic [LFSR_W-1:0] ZERO_FIX = 8'h01;

endpackage

// File: rtl/lfsr8_core.sv
// rtl/lfsr8_core.sv - 8-bit Fibonacci LFSR with seed load and step enable
module lfsr8_core
    import rand_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 8'h01
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              load,
    input  logic [LFSR_W-1:0] load_data,
    output logic [LFSR_W-1:0] R,
    output logic [LFSR_W-1:0] nxt
);

    // Next value of the register if it were stepped now; zero escapes to ZERO_FIX
    always_comb begin
        nxt = {^(R & TAP_MASK), R[LFSR_W-1:1]};
        if (R == '0) begin
            nxt = ZERO_FIX;
        end
    end

    // Register: reset to SEED, seed load wins over stepping
    always_ff @(posedge clk) begin
        if (rst) begin
            R <= SEED;
        end else if (load) begin
            R <= load_data;
        end else if (en) begin
            R <= nxt;
        end
    end

endmodule

// File: rtl/rand_arbiter.sv
// rtl/rand_arbiter.sv - round-robin arbiter handing out LFSR bytes to requesters
module rand_arbiter
    import rand_pkg::*;
#(
    parameter int                NREQ  = 4,
    parameter int                STEPS = 1,
    parameter logic [LFSR_W-1:0] SEED  = 8'h01
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    output logic [NREQ-1:0]   gnt,
    output logic [LFSR_W-1:0] rdata,
    input  logic              seed_we,
    input  logic [LFSR_W-1:0] seed_data,
    output logic              seed_ack,
    output logic              busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (STEPS > 1) ? $clog2(STEPS + 1) : 1;
    localparam logic [PW-1:0] LAST_IDX = PW'(NREQ - 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(STEPS - 1);

    state_t            state;
    state_t            state_nxt;
    logic [PW-1:0]     ptr;
    logic [PW-1:0]     win;
    logic [PW-1:0]     sel;
    logic [PW-1:0]     idx;
    logic              sel_valid;
    logic [CW-1:0]     cnt;
    logic              last_step;
    logic              start;
    logic              lfsr_load;
    logic              lfsr_en;
    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_nxt;

    assign last_step = (state == STEP) && (cnt == LAST_CNT);
    assign start     = (state == IDLE) && !seed_we && sel_valid;
    assign lfsr_load = (state == IDLE) && seed_we;
    assign lfsr_en   = (state == STEP);
    assign busy      = (state == STEP) || (state == GRANT);

    lfsr8_core #(
        .SEED (SEED)
    ) u_lfsr (
        .clk       (clk),
        .rst       (rst),
        .en        (lfsr_en),
        .load      (lfsr_load),
        .load_data (seed_data),
        .R         (lfsr_q),
        .nxt       (lfsr_nxt)
    );

    // Round-robin pick: first set request scanning upward from ptr, wrapping at NREQ-1
    always_comb begin
        sel       = '0;
        sel_valid = 1'b0;
        idx       = ptr;
        for (int i = 0; i < NREQ; i++) begin
            if (!sel_valid && req[idx]) begin
                sel       = idx;
                sel_valid = 1'b1;
            end
            idx = (idx == LAST_IDX) ? '0 : idx + PW'(1);
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: a seed load keeps the FSM idle
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = STEP;
            STEP:    if (last_step) state_nxt = GRANT;
            GRANT:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Winner latch, step counter, pointer advance and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr      <= '0;
            win      <= '0;
            cnt      <= '0;
            gnt      <= '0;
            rdata    <= '0;
            seed_ack <= 1'b0;
        end else begin
            seed_ack <= lfsr_load;
            gnt      <= '0;
            case (state)
                IDLE: begin
                    if (start) begin
                        win <= sel;
                        cnt <= '0;
                    end
                end
                STEP: begin
                    cnt <= cnt + CW'(1);
                    if (last_step) begin
                        gnt   <= {{(NREQ-1){1'b0}}, 1'b1} << win;
                        rdata <= lfsr_nxt;
                    end
                end
                GRANT: begin
                    ptr <= (win == LAST_IDX) ? '0 : win + PW'(1);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/rand_arbiter.md
Name: rand_arbiter

Overview:
- Shares one 8-bit Fibonacci LFSR random source between NREQ requesters.
- Round-robin arbitration; for each grant the LFSR is advanced STEPS times and the resulting byte is returned to the winner with a one-cycle grant pulse.
- Supports a seed load while idle.
- Sits between the board-level consumers (dice, LED patterns, game logic) and the random source. Only this block ever advances the LFSR.

Parameters:
- NREQ, 4, number of requesters (2..8).
- STEPS, 1, LFSR advances per grant (1..8); STEPS=8 yields a fully fresh byte.
- SEED, 8'h01, LFSR value after reset.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  NREQ  per-requester request level; held until the matching gnt bit is seen.
- gnt  output  NREQ  one-hot grant pulse, exactly 1 cycle, registered.
- rdata  output  8  random byte; valid only in the cycle gnt is nonzero, holds its value otherwise.
- seed_we  input  1  seed load strobe.
- seed_data  input  8  seed value.
- seed_ack  output  1  1-cycle pulse: the seed was accepted.
- busy  output  1  high in STEP and GRANT states.

Behaviour:
- Reset (rst=1 at edge):
  - R=SEED, state=IDLE, ptr=0.
  - gnt=0, rdata=8'h00, seed_ack=0, busy=0, step counter=0.
  - Reset overrides everything, including mid-STEP or GRANT. A pending grant is dropped; no gnt pulse is issued.
- LFSR step function, applied once per STEP cycle:
  - If R==8'h00, next R=8'h01.
  - Otherwise s=R[4]^R[3]^R[2]^R[0] and next R={s,R[7:1]}.
  - The LFSR never advances outside STEP.
- FSM states: IDLE, STEP, GRANT.
- IDLE:
  - seed_we=1 has priority over req. R<=seed_data, seed_ack=1 next cycle, stay IDLE. A seed of 8'h00 is legal and becomes 8'h01 on the first step.
  - Otherwise, if req!=0, select winner w = first set bit scanning from ptr upward with wrap-around (ptr, ptr+1 .. NREQ-1, 0 .. ptr-1). Latch w, clear the step counter, go to STEP.
- STEP:
  - Advance R once per cycle and increment the counter.
  - After STEPS cycles go to GRANT.
  - With the last step, register gnt[w]=1 and rdata=the new R, so the pulse is visible during the GRANT cycle.
- GRANT:
  - gnt held for this single cycle.
  - Next edge: gnt<=0, ptr<=(w+1) mod NREQ, go to IDLE.
- Latency: req sampled high in IDLE at edge k gives gnt high during cycle k+1+STEPS. Per-grant occupancy is STEPS+2 cycles.
- Commitment:
  - Once latched, the winner receives its grant even if req[w] drops during STEP.
  - req changes during STEP/GRANT are ignored.
  - A requester that keeps req high after its gnt is re-arbitrated as a new request.
- seed_we outside IDLE is ignored (no ack); the producer retries.
- Fairness: with all req held high, grants cycle 0,1,..,NREQ-1,0,... with no requester starved.
- NREQ not a power of two: ptr wrap uses explicit compare to NREQ-1, not a modulo on width.
- busy=1 exactly when state is STEP or GRANT.

Decomposition:
- Shared package rand_pkg:
  - State enum {IDLE, STEP, GRANT}.
  - Tap constants (bits 4,3,2,0), LFSR width 8, zero-state replacement 8'h01.
- Sub-module lfsr8_core (clk, rst, en, load, load_data, R; reset value SEED). It owns the step function.
- rand_arbiter holds the FSM, round-robin pointer, step counter and output registers.

Test Plan:
- Reset, STEPS=1, req=4'b0001 held → gnt=4'b0001 at the 3rd cycle after req, rdata=8'h80. Keep req → next grant 3 cycles later, rdata=8'h40.
- req=4'b1111 held after reset → gnt sequence 0001,0010,0100,1000 with rdata 80,40,20,10, then 0001 with rdata 88, then 0010 with C4. Pulses are 3 cycles apart.
- seed_we=1, seed_data=8'h00 in IDLE → seed_ack next cycle. Then req[2] → rdata=8'h01, next grant rdata=8'h80.
- STEPS=4, after reset req[1] → single gnt[1] pulse 5 cycles after req, rdata=8'h10. busy is high for 5 cycles.
- seed_we pulsed during STEP → no seed_ack, grant value unaffected (80 with STEPS=1). rst asserted during STEP → no gnt pulse, rdata=00, next grant again returns 8'h80.
- req[3] dropped one cycle after selection → gnt[3] still pulses. ptr advances, so a subsequent req=4'b1001 grants bit 0 first.
